// File: rtl/uart_serial_endpoint.sv
// rtl/uart_serial_endpoint.sv - 8N1 UART transmitter/receiver endpoint with level-held TX handshake
module uart_serial_endpoint #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic       ser_tx,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_WAIT_CLR} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shift, tx_shift_n;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
    end
  end

  // WAIT_CLR is what keeps a held tx_start from launching a second frame
  always_comb begin
    tx_state_n   = tx_state;
    tx_cnt_n     = tx_cnt;
    tx_idx_n     = tx_idx;
    tx_shift_n   = tx_shift;
    tx_busy      = 1'b0;
    tx_clear_req = 1'b0;
    ser_tx       = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_n = TX_START;
          tx_shift_n = tx_data;
          tx_cnt_n   = '0;
        end
      end
      TX_START: begin
        tx_busy = 1'b1;
        ser_tx  = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_state_n = TX_DATA;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        tx_busy = 1'b1;
        ser_tx  = tx_shift[tx_idx];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) tx_state_n = TX_STOP;
          else                tx_idx_n   = tx_idx + 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        tx_busy = 1'b1;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n   = '0;
          tx_state_n = tx_start ? TX_WAIT_CLR : TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_WAIT_CLR: begin
        if (tx_start) tx_clear_req = 1'b1;
        else          tx_state_n   = TX_IDLE;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  logic          rx_s1, rx_s2, rx_prev;
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_shift, rx_shift_n, rx_data_n;
  logic          rx_valid_n, rx_frame_err_n;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= ser_rx;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_state     <= rx_state_n;
      rx_cnt       <= rx_cnt_n;
      rx_idx       <= rx_idx_n;
      rx_shift     <= rx_shift_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_frame_err <= rx_frame_err_n;
    end
  end

  // START waits half a bit so every later sample lands mid-bit one full bit apart
  always_comb begin
    rx_state_n     = rx_state;
    rx_cnt_n       = rx_cnt;
    rx_idx_n       = rx_idx;
    rx_shift_n     = rx_shift;
    rx_data_n      = rx_data;
    rx_valid_n     = 1'b0;
    rx_frame_err_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          if (rx_s2) begin
            rx_data_n  = rx_shift;
            rx_valid_n = 1'b1;
          end else begin
            rx_frame_err_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_serial_endpoint.sv
// tb/tb_uart_serial_endpoint.sv - directed bench for uart_serial_endpoint with RX scoreboard
module tb_uart_serial_endpoint;
  localparam int CPB = 4;

  logic       clock    = 1'b0;
  logic       resetb   = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_busy, tx_clear_req, ser_tx, ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err;
  logic       rx_drv   = 1'b1;
  logic       loop_en  = 1'b0;

  assign ser_rx = loop_en ? ser_tx : rx_drv;

  uart_serial_endpoint #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_asserts = 0;
  int n_fail    = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int last_valid_cyc = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetb && rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      check("rx_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (resetb && rx_frame_err) ferr_cnt++;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ser_tx"}, 32'(ser_tx), 32'd1);
    check({tag, "_tx_busy"}, 32'(tx_busy), 32'd0);
    check({tag, "_tx_clear_req"}, 32'(tx_clear_req), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'h00);
  endtask

  task automatic check_tx_frame(input logic [7:0] d, input int drop_at);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clock);
      if (i == 0) tx_data = ~d;
      if (i == drop_at) tx_start = 1'b0;
      check("tx_bit", 32'(ser_tx), 32'(fr[i / CPB]));
      check("tx_busy_frame", 32'(tx_busy), 32'd1);
      check("tx_clear_req_frame", 32'(tx_clear_req), 32'd0);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = fr[b];
      repeat (CPB) @(negedge clock);
    end
    rx_drv = 1'b1;
  endtask

  task automatic send_tx_loop(input logic [7:0] d);
    int k;
    exp_q.push_back(d);
    tx_data  = d;
    tx_start = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!tx_busy && k < 4);
    check("loop_tx_busy_rise", 32'(tx_busy), 32'd1);
    tx_start = 1'b0;
    k = 0;
    while (tx_busy && k < 12 * CPB) begin @(negedge clock); k++; end
    check("loop_tx_busy_fall", 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int t0, v0, f0, k;
    logic [7:0] loop_bytes [3];
    loop_bytes = '{8'h00, 8'hFF, 8'h55};

    resetb = 1'b0;
    rx_drv = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetb = 1'b1;
    @(negedge clock);

    check("tx_busy_idle", 32'(tx_busy), 32'd0);
    tx_data  = 8'h0F;
    tx_start = 1'b1;
    check_tx_frame(8'h0F, -1);
    @(negedge clock);
    check("tx0f_busy_end", 32'(tx_busy), 32'd0);
    check("tx0f_clear_req", 32'(tx_clear_req), 32'd1);
    repeat (8) begin
      @(negedge clock);
      check("tx0f_no_second_busy", 32'(tx_busy), 32'd0);
      check("tx0f_no_second_ser", 32'(ser_tx), 32'd1);
      check("tx0f_clear_held", 32'(tx_clear_req), 32'd1);
    end
    tx_start = 1'b0;
    #1;
    check("tx0f_clear_drop", 32'(tx_clear_req), 32'd0);
    @(negedge clock);
    check("tx0f_clear_after", 32'(tx_clear_req), 32'd0);

    tx_data  = 8'h3D;
    tx_start = 1'b1;
    check_tx_frame(8'h3D, 10);
    @(negedge clock);
    check("tx3d_busy_end", 32'(tx_busy), 32'd0);
    check("tx3d_clear_req", 32'(tx_clear_req), 32'd0);
    check("tx3d_idle_line", 32'(ser_tx), 32'd1);

    t0 = cyc;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    repeat (5) @(negedge clock);
    check("rxa5_count", 32'(valid_cnt - v0), 32'd1);
    check("rxa5_latency", 32'(last_valid_cyc - (t0 + 1)), 32'(2 + (19 * CPB) / 2));
    check("rxa5_data", 32'(rx_data), 32'hA5);
    check("rxa5_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx_drv = 1'b0;
    @(negedge clock);
    rx_drv = 1'b1;
    repeat (12 * CPB) @(negedge clock);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    send_rx(8'h3C, 1'b0);
    repeat (3 * CPB) @(negedge clock);
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_data_kept", 32'(rx_data), 32'hA5);

    loop_en = 1'b1;
    v0 = valid_cnt;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) send_tx_loop(loop_bytes[i]);
    k = 0;
    while (exp_q.size() > 0 && k < 20 * CPB) begin @(negedge clock); k++; end
    repeat (2) @(negedge clock);
    check("loop_q_empty", 32'(exp_q.size()), 32'd0);
    check("loop_count", 32'(valid_cnt - v0), 32'd3);
    check("loop_last_data", 32'(rx_data), 32'h55);

    tx_data  = 8'hF0;
    tx_start = 1'b1;
    repeat (15) @(negedge clock);
    check("mid_frame_busy", 32'(tx_busy), 32'd1);
    resetb = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    tx_start = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    repeat (12 * CPB) @(negedge clock);
    check("post_reset_count", 32'(valid_cnt - v0), 32'd3);
    check("post_reset_ser_tx", 32'(ser_tx), 32'd1);
    check("post_reset_busy", 32'(tx_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_serial_endpoint.md
Name:
uart_serial_endpoint

Overview:
- 8N1 UART transmitter/receiver endpoint for the chip-level bench; talks to the SoC UART pins (SoC TX -> ser_rx, ser_tx -> SoC RX).
- Host side uses a level-held start request with a busy flag and a clear-request flag.
- Received bytes are presented as single-cycle valid pulses.

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per UART bit (40 MHz / 9600 baud); must be >= 4.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- resetb  input  1  synchronous active-low reset.
- tx_start  input  1  host transmit request; level, held high by the host until tx_busy falls.
- tx_data  input  8  byte to send; sampled when a frame is accepted.
- tx_busy  output  1  high while a TX frame is in progress.
- tx_clear_req  output  1  high after a frame completes while tx_start is still high; asks the host to drop tx_start.
- ser_tx  output  1  serial out, idle high.
- ser_rx  input  1  serial in, idle high, asynchronous.
- rx_data  output  8  last received byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated with a good frame.
- rx_frame_err  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset (resetb low at an edge):
  - ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0, rx_valid=0, rx_frame_err=0.
  - Both FSMs go to IDLE; TX is re-armed.
  - Reset mid-frame aborts the frame; ser_tx is high after that edge.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP, WAIT_CLR.
  - IDLE -> START when tx_start=1 and armed. tx_data is latched; from the next cycle ser_tx=0 and tx_busy=1.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: bit index 0..7, each for CLKS_PER_BIT cycles, then -> STOP.
  - STOP: ser_tx=1 for CLKS_PER_BIT cycles. tx_busy stays 1 for the whole frame: 10*CLKS_PER_BIT cycles total.
  - After STOP, tx_busy=0. If tx_start is still 1, go to WAIT_CLR with tx_clear_req=1; otherwise go to IDLE.
  - WAIT_CLR -> IDLE once tx_start=0; tx_clear_req=0 in that same cycle.
  - A held tx_start never causes a second frame; the host must drop it and raise it again.
  - tx_start falling mid-frame does not abort; the frame completes.
  - tx_data changes after acceptance are ignored.
- RX path:
  - ser_rx passes through a 2-flop synchronizer, giving 2 cycles of latency.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 1->0 transition -> START.
  - START: sample at CLKS_PER_BIT/2 (integer division). If the line is 1 it was a glitch -> IDLE, no outputs. If 0, continue.
  - DATA: sample each of the 8 bits every CLKS_PER_BIT cycles at mid-bit; shift in LSB first.
  - STOP: sample at mid stop bit.
    - Stop bit 1: rx_data <= shifted byte and rx_valid=1 for one cycle.
    - Stop bit 0: rx_frame_err=1 for one cycle; rx_data is unchanged.
  - After STOP -> IDLE immediately. A start edge during the second half of the stop bit is detected on the following cycles.
  - Back-to-back frames (no idle gap) are received without loss.
- TX and RX are fully independent. Simultaneous TX and RX activity, including ser_tx looped back to ser_rx, must work.
- Counters: bit-time counter sized to $clog2(CLKS_PER_BIT)+1 bits; 3-bit bit index. Counters wrap to 0 at each bit boundary.

Test Plan:
- Reset: hold resetb=0 for 3 cycles with ser_rx=1 -> ser_tx=1, tx_busy=0, tx_clear_req=0, rx_valid=0, rx_data=8'h00.
- TX 8'h0F with CLKS_PER_BIT=4:
  - Raise tx_start with tx_data=8'h0F -> ser_tx reads 0,1,1,1,1,0,0,0,0,1, each level held for 4 cycles.
  - tx_busy is high for exactly 40 cycles.
  - tx_clear_req rises when tx_busy falls and clears the cycle tx_start drops.
  - No second frame is sent.
- TX 8'h3D: start a frame, then drop tx_start at cycle 10 -> the full frame is still sent (bits LSB first 1,0,1,1,1,1,0,0); tx_clear_req never asserts.
- RX good frame 8'hA5: drive it on ser_rx -> exactly one rx_valid pulse with rx_data=8'hA5, about 2 + 9.5*CLKS_PER_BIT cycles after the start edge.
- RX errors:
  - A 1-cycle low glitch on ser_rx -> no rx_valid and no rx_frame_err.
  - A frame with stop bit 0 -> rx_frame_err pulse and rx_data unchanged.
- Loopback: tie ser_tx to ser_rx, send 8'h00, 8'hFF, 8'h55 back-to-back -> three rx_valid pulses with matching data. Then assert resetb=0 mid-frame -> all outputs at their reset values on the next cycle.
